// File: rtl/imem_run_controller.sv
// Instruction memory and run sequencer for cpu_4bit: host loads while the CPU is held in reset,
// runs from address 0 on start, returns to hold on stop/halt. Optional cycle budget: RUN_LIMIT_EN.
module imem_run_controller #(
    parameter int                   INSTR_W    = 8,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = 8'hFF,
    parameter logic [7:0]           MAX_CYCLES = 8'd200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [3:0]          load_addr,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic                start,
    input  logic                stop,
    input  logic [3:0]          instruction_addr,
    output logic [INSTR_W-1:0]  instruction,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic [7:0]          run_cycles,
    output logic                timeout
);

    // state | meaning
    // IDLE  | after reset; CPU held, host may load
    // RUN   | CPU released and fetching; loads ignored
    // DONE  | run ended by stop, halt or budget; CPU held, host may load
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

`ifdef RUN_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t                 r_state;
    logic                   r_cpu_reset;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_run_cycles;
    logic                   r_timeout;
    logic [INSTR_W-1:0]     r_mem [16];

    logic                   w_load_ready;
    logic                   w_halt;
    logic                   w_limit_hit;
    logic [7:0]             w_cycles_next;

    assign w_load_ready  = (r_state != S_RUN);
    assign instruction   = r_mem[instruction_addr];
    assign w_halt        = (instruction == HALT_INSTR);
    assign w_limit_hit   = LIMIT_EN && (r_run_cycles == MAX_CYCLES - 8'd1);
    assign w_cycles_next = (r_run_cycles == 8'hFF) ? 8'hFF : r_run_cycles + 8'd1;

    // Memory has no reset so a program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (load_valid && w_load_ready) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_run_cycles <= 8'd0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_cpu_reset  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_run_cycles <= 8'd0;
                        r_timeout    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_run_cycles <= w_cycles_next;
                    if (stop || w_halt || w_limit_hit) begin
                        r_state     <= S_DONE;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        // stop/halt on the budget edge wins, so no timeout
                        r_timeout   <= !(stop || w_halt);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_reset <= 1'b1;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign cpu_reset  = r_cpu_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign run_cycles = r_run_cycles;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_imem_run_controller.sv
// Bench for imem_run_controller: directed scenarios then random load/start/stop traffic,
// compared each cycle against a cycle-level behavioural model of memory, run status and counters.
module tb_imem_run_controller;

    localparam logic [7:0] HALT = 8'hFF;
    localparam logic [7:0] MAXC = 8'd10;
`ifdef RUN_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] instruction_addr = '0;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic [7:0] run_cycles;
    logic       timeout;

    imem_run_controller #(.INSTR_W(8), .HALT_INSTR(HALT), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .start(start), .stop(stop),
        .instruction_addr(instruction_addr), .instruction(instruction),
        .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .run_cycles(run_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_mem [16];
    bit         m_valid [16];
    bit         m_run = 0, m_done = 0, m_to = 0;
    int         m_cyc = 0;
    logic [3:0] pc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("cpu_reset", cpu_reset, !m_run);
        chk("load_ready", load_ready, !m_run);
        chk("run_cycles", run_cycles, m_cyc);
        chk("timeout", timeout, m_to);
        if (m_valid[pc]) chk("instruction", instruction, m_mem[pc]);
    endtask

    // One clock: advance the model from the inputs presented, clock the DUT, compare.
    task automatic tick();
        bit halt;
        int prev;
        halt = m_run && m_valid[pc] && (m_mem[pc] == HALT);
        if (load_valid && !m_run) begin
            m_mem[load_addr]   = load_data;
            m_valid[load_addr] = 1;
        end
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_cyc = 0; m_to = 0; pc = 0;
            end
        end else begin
            prev  = m_cyc;
            m_cyc = (m_cyc + 1 > 255) ? 255 : m_cyc + 1;
            if (stop || halt) begin
                m_run = 0; m_done = 1;
            end else if (LIM && prev == MAXC - 1) begin
                m_run = 0; m_done = 1; m_to = 1;
            end else begin
                pc = pc + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        start = 0; stop = 0; load_valid = 0;
        instruction_addr = pc;
        #1;
        check_all();
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_valid = 1; load_addr = a; load_data = d;
        tick();
    endtask

    task automatic peek(input logic [3:0] a, input string tag);
        instruction_addr = a;
        #1;
        chk(tag, instruction, m_mem[a]);
        instruction_addr = pc;
        #1;
    endtask

    function automatic logic [7:0] non_halt();
        logic [7:0] v;
        v = 8'($urandom_range(0, 254));
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_mem[i] = '0; end
        #12;
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cycles", run_cycles, 8'd0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_ready", load_ready, 1'b1);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 16; i++) load(4'(i), non_halt());

        // program 12,34,FF then run to halt
        load(4'd0, 8'h12); load(4'd1, 8'h34); load(4'd2, 8'hFF);
        start = 1; tick();
        chk("t2_busy", busy, 1'b1);
        tick(); tick(); tick();
        chk("t2_done", done, 1'b1);
        chk("t2_cycles", run_cycles, 8'd3);
        chk("t2_cpu_reset", cpu_reset, 1'b1);

        // loads during RUN are dropped; stop ends the run
        load(4'd2, 8'h22);
        start = 1; tick();
        load_valid = 1; load_addr = 4'd5; load_data = 8'hAA; tick();
        chk("t3_ready", load_ready, 1'b0);
        stop = 1; tick();
        chk("t4_done", done, 1'b1);
        chk("t4_cpu_reset", cpu_reset, 1'b1);
        peek(4'd5, "t3_mem5");
        start = 1; tick();
        chk("t4_restart", run_cycles, 8'd0);

        // async reset in the middle of a run
        tick(); tick();
        reset = 0;
        #1;
        chk("t1_cpu_reset", cpu_reset, 1'b1);
        chk("t1_busy", busy, 1'b0);
        m_run = 0; m_done = 0; m_cyc = 0; m_to = 0; pc = 0;
        instruction_addr = 0;
        #1;
        reset = 1;
        check_all();
        peek(4'd3, "t1_mem3");

        // write and start on the same edge
        start = 1; load_valid = 1; load_addr = 4'd0; load_data = 8'h0F;
        tick();
        chk("t5_first_fetch", instruction, 8'h0F);
        stop = 1; tick();

        // program without a halt word: budget or endless run
        for (int i = 1; i < 16; i++) load(4'(i), non_halt());
        start = 1; tick();
        for (int i = 0; i < 299; i++) tick();
        if (!LIM) begin
            chk("t6_busy", busy, 1'b1);
            chk("t6_sat", run_cycles, 8'hFF);
        end else begin
            chk("t6_timeout", timeout, 1'b1);
            chk("t6_cycles", run_cycles, 32'(MAXC));
        end
        stop = 1; tick();

        for (int i = 0; i < 3000; i++) begin
            load_valid = ($urandom_range(0, 1) == 1);
            load_addr  = 4'($urandom_range(0, 15));
            load_data  = ($urandom_range(0, 7) == 0) ? HALT : non_halt();
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
